hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Decode-stage hazard/stall controller for the 5-stage MIPS pipeline; the counterpart of the forwarding unit.
//  Forwarding consumes MEM/WB writeback info. This block produces the stalls and bubbles that forwarding cannot cover.
//  It keeps an internal shadow of the in-flight destination registers (EX/MEM/WB) and detects load-use and branch-in-decode hazards.
//  It freezes the pipe while data memory is busy, counts stall cycles and flags memory timeouts.
// PARAMETERS
//  CNT_W        16   width of saturating stall-cycle counter
//  MEM_TIMEOUT  64   consecutive mem-wait cycles before mem_timeout asserts
// PORTS
//  clk          in   1   pipeline clock
//  pc_rst_n     in   1   reset, synchronous, active-low
//  d_valid      in   1   decode holds a real instruction
//  d_rs, d_rt   in   5   decode source registers
//  d_uses_rs    in   1   decode instruction reads rs
//  d_uses_rt    in   1   decode instruction reads rt
//  d_is_branch  in   1   decode instr is beq/bne (compares in decode)
//  d_writeReg   in   5   decode destination register
//  d_RW         in   1   decode instr writes a register
//  d_memRead    in   1   decode instr is a load
//  d_memOp      in   1   decode instr accesses data memory (ld or st)
//  d_taken      in   1   branch in decode resolved taken this cycle
//  mem_ready    in   1   data memory completes access this cycle
//  pc_stall     out  1   hold PC
//  d_stall      out  1   hold IF/ID
//  x_bubble     out  1   inject NOP into ID/EX
//  if_flush     out  1   squash IF/ID (taken branch)
//  pipe_freeze  out  1   hold ID/EX, EX/MEM, MEM/WB (mem wait)
//  stall_cnt    out  CNT_W  cycles with pc_stall=1, saturating
//  mem_timeout  out  1   sticky: mem wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Shadow state: three entries X, M, W = {valid, wr, load, memop, reg[4:0]}; all invalid at reset.
//  Advance on each edge unless pipe_freeze:
//   - W<=M; M<=X.
//   - X<=decode fields when d_valid & !d_stall, otherwise X<=invalid (a bubble).
//  Register 0 never matches (writes to $0 are ignored for hazards).
//  match(E,r) = E.valid & E.wr & E.reg==r & r!=0, applied to the sources in use.
//  Stall conditions, combinational from shadow state plus D inputs:
//   - load-use: d_valid & match(X, src) & X.load.
//   - branch: d_valid & d_is_branch & (match(X, src) | (match(M, src) & M.load)).
//  hz = either condition; pc_stall = d_stall = x_bubble = hz | pipe_freeze.
//  x_bubble is forced 0 while pipe_freeze (ID/EX holds, it is not bubbled).
//  pipe_freeze = M.valid & M.memop & !mem_ready.
//  if_flush = d_valid & d_is_branch & d_taken & !hz & !pipe_freeze.
//   - A stalled branch never flushes.
//  Latency: a load in EX stalls its dependent by exactly 1 cycle.
//   - A branch dependent on an ALU op in EX stalls 1 cycle; one dependent on a load in EX stalls 2 cycles.
//  stall_cnt increments each cycle pc_stall=1; it holds at all-ones.
//  Mem-wait counter counts consecutive pipe_freeze cycles and clears when pipe_freeze=0.
//   - Reaching MEM_TIMEOUT sets mem_timeout; only reset clears it.
//  Reset: all outputs 0, counters 0, shadow entries invalid, mid-operation included.
//   - Reset is sampled on clk; with pc_rst_n low, outputs are 0 the cycle after.
//  Simultaneous events: a mem freeze outranks a hazard, and the shadow does not advance.
//   - The hazard re-evaluates after the freeze releases.
// TESTING
//  lw $2 then add $3,$2,$4 -> one cycle: pc_stall=d_stall=x_bubble=1; next cycle all 0; stall_cnt=1.
//  lw $0 then add $3,$0,$4 -> no stall (reg 0 exempt).
//  add $5 then beq $5,$6 -> 1 stall cycle; lw $5 then beq $5,$6 -> 2 stall cycles.
//  lw in MEM with mem_ready=0 for 3 cycles -> pipe_freeze=1 and x_bubble=0 for 3 cycles, shadow unchanged; release on ready.
//  mem_ready=0 for MEM_TIMEOUT cycles -> mem_timeout=1 and stays 1 after ready; pc_rst_n=0 clears it.
//  beq taken, no hazard -> if_flush=1 for 1 cycle; same beq during a load-use stall -> if_flush=0 until the stall clears.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard/stall controller: tracks in-flight destinations, raises load-use and
// branch-in-decode stalls, freezes the pipe on data-memory wait and flags memory timeouts.
module hazard_stall_unit #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             pc_rst_n,
   input  logic             d_valid,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic             d_uses_rs,
   input  logic             d_uses_rt,
   input  logic             d_is_branch,
   input  logic [4:0]       d_writeReg,
   input  logic             d_RW,
   input  logic             d_memRead,
   input  logic             d_memOp,
   input  logic             d_taken,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             d_stall,
   output logic             x_bubble,
   output logic             if_flush,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_timeout
);

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic       load;
      logic       memop;
      logic [4:0] rd;
   } shadow_t;

   localparam shadow_t    SHADOW_NONE = '0;
   localparam int         WAIT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

   // The WB-stage producer is never consulted for a stall (forwarding covers it), so only
   // the EX and MEM entries are held; the WB slot would be write-only state.
   shadow_t           r_x;
   shadow_t           r_m;
   logic              r_act;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [WAIT_W-1:0] r_wait;
   logic              r_timeout;

   logic    w_x_hit;
   logic    w_m_hit;
   logic    w_load_use;
   logic    w_branch_hz;
   logic    w_hz;
   logic    w_freeze;
   shadow_t w_dec;

   function automatic logic match(input shadow_t e, input logic [4:0] r);
      return e.valid & e.wr & (e.rd == r) & (r != 5'd0);
   endfunction

   assign w_x_hit     = (d_uses_rs & match(r_x, d_rs)) | (d_uses_rt & match(r_x, d_rt));
   assign w_m_hit     = (d_uses_rs & match(r_m, d_rs)) | (d_uses_rt & match(r_m, d_rt));
   assign w_load_use  = d_valid & w_x_hit & r_x.load;
   assign w_branch_hz = d_valid & d_is_branch & (w_x_hit | (w_m_hit & r_m.load));
   assign w_hz        = w_load_use | w_branch_hz;
   assign w_freeze    = r_m.valid & r_m.memop & ~mem_ready;

   assign w_dec = '{valid: 1'b1, wr: d_RW, load: d_memRead, memop: d_memOp, rd: d_writeReg};

   // r_act keeps every output low from the first reset edge until the first edge out of
   // reset, even while decode inputs are still toggling.
   assign pipe_freeze = r_act & w_freeze;
   assign pc_stall    = r_act & (w_hz | w_freeze);
   assign d_stall     = pc_stall;
   assign x_bubble    = r_act & w_hz & ~w_freeze;
   assign if_flush    = r_act & d_valid & d_is_branch & d_taken & ~w_hz & ~w_freeze;
   assign stall_cnt   = r_stall_cnt;
   assign mem_timeout = r_timeout;

   // NOTE: state updates use <= so every register samples pre-edge values of its peers.
   always_ff @(posedge clk) begin
      if (!pc_rst_n) begin
         r_x         <= SHADOW_NONE;
         r_m         <= SHADOW_NONE;
         r_act       <= 1'b0;
         r_stall_cnt <= '0;
         r_wait      <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_act <= 1'b1;
         if (!w_freeze) begin
            r_m <= r_x;
            r_x <= (d_valid && !w_hz) ? w_dec : SHADOW_NONE;
         end
         if (pc_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_freeze) begin
            if (r_wait != WAIT_MAX)
               r_wait <= r_wait + 1'b1;
            if (r_wait >= WAIT_LAST)
               r_timeout <= 1'b1;
         end else begin
            r_wait <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, $0 exemption, branch stalls, flush,
// memory freeze, timeout, counter saturation and reset.
module tb_hazard_stall_unit;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 8;

   logic             clk;
   logic             pc_rst_n;
   logic             d_valid;
   logic [4:0]       d_rs;
   logic [4:0]       d_rt;
   logic             d_uses_rs;
   logic             d_uses_rt;
   logic             d_is_branch;
   logic [4:0]       d_writeReg;
   logic             d_RW;
   logic             d_memRead;
   logic             d_memOp;
   logic             d_taken;
   logic             mem_ready;
   logic             pc_stall;
   logic             d_stall;
   logic             x_bubble;
   logic             if_flush;
   logic             pipe_freeze;
   logic [CNT_W-1:0] stall_cnt;
   logic             mem_timeout;

   int n_checks = 0;
   int n_errors = 0;

   hazard_stall_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .pc_rst_n(pc_rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .d_is_branch(d_is_branch),
      .d_writeReg(d_writeReg), .d_RW(d_RW), .d_memRead(d_memRead), .d_memOp(d_memOp),
      .d_taken(d_taken), .mem_ready(mem_ready), .pc_stall(pc_stall), .d_stall(d_stall),
      .x_bubble(x_bubble), .if_flush(if_flush), .pipe_freeze(pipe_freeze),
      .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // {pc_stall, d_stall, x_bubble, if_flush, pipe_freeze}
   function automatic logic [4:0] outs();
      return {pc_stall, d_stall, x_bubble, if_flush, pipe_freeze};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_nop();
      d_valid = 0; d_rs = 0; d_rt = 0; d_uses_rs = 0; d_uses_rt = 0; d_is_branch = 0;
      d_writeReg = 0; d_RW = 0; d_memRead = 0; d_memOp = 0; d_taken = 0;
      #1;
   endtask

   task automatic drive_lw(input logic [4:0] rd, input logic [4:0] base);
      drive_nop();
      d_valid = 1; d_rs = base; d_uses_rs = 1; d_writeReg = rd; d_RW = 1;
      d_memRead = 1; d_memOp = 1;
      #1;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      drive_nop();
      d_valid = 1; d_rs = rs; d_rt = rt; d_uses_rs = 1; d_uses_rt = 1; d_writeReg = rd; d_RW = 1;
      #1;
   endtask

   task automatic drive_beq(input logic [4:0] rs, input logic [4:0] rt, input logic taken);
      drive_nop();
      d_valid = 1; d_rs = rs; d_rt = rt; d_uses_rs = 1; d_uses_rt = 1; d_is_branch = 1;
      d_taken = taken;
      #1;
   endtask

   task automatic do_reset();
      pc_rst_n = 0; mem_ready = 1;
      drive_nop();
      tick();
      tick();
      pc_rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      pc_rst_n = 0; mem_ready = 0;
      drive_beq(5'd3, 5'd4, 1'b1);
      tick();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL reset_outs: got %b expected %b", outs(), 5'b00000);
      end
      n_checks++;
      if (stall_cnt !== 4'd0 || mem_timeout !== 1'b0) begin
         n_errors++; $display("FAIL reset_cnt: got cnt=%0d to=%b expected 0 0", stall_cnt, mem_timeout);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive_lw(5'd2, 5'd1);
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL lu_first: got %b expected %b", outs(), 5'b00000);
      end
      tick();
      drive_alu(5'd3, 5'd2, 5'd4);
      n_checks++;
      if (outs() !== 5'b11100) begin
         n_errors++; $display("FAIL lu_stall: got %b expected %b", outs(), 5'b11100);
      end
      tick();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL lu_release: got %b expected %b", outs(), 5'b00000);
      end
      n_checks++;
      if (stall_cnt !== 4'd1) begin
         n_errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
      end
      tick();
      drive_nop();
   endtask

   task automatic test_reg0();
      do_reset();
      drive_lw(5'd0, 5'd1);
      tick();
      drive_alu(5'd3, 5'd0, 5'd4);
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL reg0_stall: got %b expected %b", outs(), 5'b00000);
      end
      tick();
      n_checks++;
      if (stall_cnt !== 4'd0) begin
         n_errors++; $display("FAIL reg0_cnt: got %0d expected 0", stall_cnt);
      end
      drive_nop();
   endtask

   task automatic test_branch_alu();
      do_reset();
      drive_alu(5'd5, 5'd1, 5'd1);
      tick();
      drive_beq(5'd5, 5'd6, 1'b0);
      n_checks++;
      if (outs() !== 5'b11100) begin
         n_errors++; $display("FAIL br_alu_stall: got %b expected %b", outs(), 5'b11100);
      end
      tick();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL br_alu_release: got %b expected %b", outs(), 5'b00000);
      end
      tick();
      drive_nop();
   endtask

   task automatic test_branch_load();
      do_reset();
      drive_lw(5'd5, 5'd1);
      tick();
      drive_beq(5'd6, 5'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (outs() !== 5'b11100) begin
            n_errors++; $display("FAIL br_lw_stall%0d: got %b expected %b", i, outs(), 5'b11100);
         end
         tick();
      end
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL br_lw_release: got %b expected %b", outs(), 5'b00000);
      end
      n_checks++;
      if (stall_cnt !== 4'd2) begin
         n_errors++; $display("FAIL br_lw_cnt: got %0d expected 2", stall_cnt);
      end
      tick();
      drive_nop();
   endtask

   task automatic test_flush();
      do_reset();
      drive_beq(5'd9, 5'd10, 1'b1);
      n_checks++;
      if (outs() !== 5'b00010) begin
         n_errors++; $display("FAIL flush_free: got %b expected %b", outs(), 5'b00010);
      end
      tick();
      drive_nop();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL flush_one_cycle: got %b expected %b", outs(), 5'b00000);
      end
      drive_lw(5'd9, 5'd1);
      tick();
      drive_beq(5'd9, 5'd10, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (outs() !== 5'b11100) begin
            n_errors++; $display("FAIL flush_held%0d: got %b expected %b", i, outs(), 5'b11100);
         end
         tick();
      end
      n_checks++;
      if (outs() !== 5'b00010) begin
         n_errors++; $display("FAIL flush_after_stall: got %b expected %b", outs(), 5'b00010);
      end
      tick();
      drive_nop();
   endtask

   task automatic test_freeze();
      do_reset();
      drive_lw(5'd7, 5'd1);
      tick();
      drive_lw(5'd8, 5'd1);
      tick();
      drive_alu(5'd3, 5'd8, 5'd4);
      mem_ready = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (outs() !== 5'b11001) begin
            n_errors++; $display("FAIL freeze_cyc%0d: got %b expected %b", i, outs(), 5'b11001);
         end
         tick();
      end
      mem_ready = 1;
      #1;
      n_checks++;
      if (outs() !== 5'b11100) begin
         n_errors++; $display("FAIL freeze_rehazard: got %b expected %b", outs(), 5'b11100);
      end
      tick();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL freeze_release: got %b expected %b", outs(), 5'b00000);
      end
      n_checks++;
      if (stall_cnt !== 4'd4 || mem_timeout !== 1'b0) begin
         n_errors++; $display("FAIL freeze_cnt: got cnt=%0d to=%b expected 4 0", stall_cnt, mem_timeout);
      end
      tick();
      drive_nop();
   endtask

   task automatic test_timeout();
      do_reset();
      drive_lw(5'd7, 5'd1);
      tick();
      drive_nop();
      tick();
      mem_ready = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == MEM_TIMEOUT - 1) begin
            n_checks++;
            if (mem_timeout !== 1'b0) begin
               n_errors++; $display("FAIL to_early: got %b expected 0 after %0d cycles", mem_timeout, i);
            end
         end
         if (i == MEM_TIMEOUT) begin
            n_checks++;
            if (mem_timeout !== 1'b1) begin
               n_errors++; $display("FAIL to_set: got %b expected 1 after %0d cycles", mem_timeout, i);
            end
         end
      end
      n_checks++;
      if (stall_cnt !== 4'd15) begin
         n_errors++; $display("FAIL cnt_saturate: got %0d expected 15", stall_cnt);
      end
      mem_ready = 1;
      tick();
      n_checks++;
      if (mem_timeout !== 1'b1 || pipe_freeze !== 1'b0) begin
         n_errors++; $display("FAIL to_sticky: got to=%b pf=%b expected 1 0", mem_timeout, pipe_freeze);
      end
      pc_rst_n = 0;
      tick();
      n_checks++;
      if (mem_timeout !== 1'b0 || stall_cnt !== 4'd0) begin
         n_errors++; $display("FAIL to_clear: got to=%b cnt=%0d expected 0 0", mem_timeout, stall_cnt);
      end
      pc_rst_n = 1;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_lw(5'd7, 5'd1);
      tick();
      drive_nop();
      tick();
      mem_ready = 0;
      drive_alu(5'd3, 5'd7, 5'd2);
      tick();
      tick();
      pc_rst_n = 0;
      tick();
      n_checks++;
      if (outs() !== 5'b00000 || stall_cnt !== 4'd0) begin
         n_errors++; $display("FAIL mid_reset: got %b cnt=%0d expected 00000 0", outs(), stall_cnt);
      end
      pc_rst_n = 1;
      tick();
      n_checks++;
      if (outs() !== 5'b00000) begin
         n_errors++; $display("FAIL mid_shadow_clear: got %b expected %b", outs(), 5'b00000);
      end
      mem_ready = 1;
      drive_nop();
   endtask

   initial begin
      pc_rst_n = 0;
      mem_ready = 1;
      drive_nop();
      test_reset();
      test_load_use();
      test_reg0();
      test_branch_alu();
      test_branch_load();
      test_flush();
      test_freeze();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
